// File: rtl/instruction_ram_if.sv
// instruction_ram_if: fetch and program-load signals between the CPU/loader and instruction_ram
interface instruction_ram_if #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  fetch_enable;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  instruction_valid;
  logic                  busy;
  logic                  load_start;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_done;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  checksum_error;
  modport master (
    output address, fetch_enable, load_start, load_data, load_valid, load_last,
    input  instruction, instruction_valid, busy, load_ready, load_done, load_count, checksum_error
  );
  modport slave (
    input  address, fetch_enable, load_start, load_data, load_valid, load_last,
    output instruction, instruction_valid, busy, load_ready, load_done, load_count, checksum_error
  );
endinterface

// File: rtl/instruction_ram.sv
// instruction_ram: loadable program store with registered fetch; IRAM_CHECKSUM_EN turns the last load beat into an XOR checksum
module instruction_ram #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD = '0
) (
  input logic Clock,
  input logic Reset,
  instruction_ram_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
`ifdef IRAM_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  typedef enum logic {RUN, LOAD} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [DATA_WIDTH-1:0] sum;
  logic accept, wr, load_end, in_range;
  always_comb begin
    accept = state == LOAD && bus.load_valid;
    wr = accept && !(CSUM && bus.load_last);
    load_end = accept && (bus.load_last || ptr == PW'(DEPTH - 1));
    in_range = {1'b0, bus.address} < (ADDR_WIDTH + 1)'(DEPTH);
  end
  always_ff @(posedge Clock)
    if (Reset && wr) mem[ptr] <= bus.load_data;
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= RUN;
      bus.instruction <= FILL_WORD;
      bus.instruction_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.load_ready <= 1'b0;
      bus.load_done <= 1'b0;
      bus.load_count <= '0;
      bus.checksum_error <= 1'b0;
      ptr <= '0;
      sum <= '0;
    end else if (state == RUN) begin
      bus.load_done <= 1'b0;
      bus.instruction_valid <= bus.fetch_enable;
      if (bus.fetch_enable) bus.instruction <= in_range ? mem[bus.address[PW-1:0]] : FILL_WORD;
      else if (bus.load_start) bus.instruction <= FILL_WORD;
      if (bus.load_start) begin
        state <= LOAD;
        bus.busy <= 1'b1;
        bus.load_ready <= 1'b1;
        bus.load_count <= '0;
        bus.checksum_error <= 1'b0;
        ptr <= '0;
        sum <= '0;
      end
    end else begin
      bus.instruction <= FILL_WORD;
      bus.instruction_valid <= 1'b0;
      if (wr) begin
        ptr <= ptr + 1'b1;
        bus.load_count <= bus.load_count + 1'b1;
        sum <= sum ^ bus.load_data;
      end
      if (load_end) begin
        state <= RUN;
        bus.busy <= 1'b0;
        bus.load_ready <= 1'b0;
        bus.load_done <= 1'b1;
        // an auto-end with no checksum beat counts as a checksum failure
        bus.checksum_error <= CSUM && (!bus.load_last || bus.load_data != sum);
      end
    end
  end
endmodule
